axi_lite_mem_responder: RTL and testbench
=========================================

Name: axi_lite_mem_responder

Overview:
- Synthesizable AXI4-Lite subordinate (memory-backed responder) with ID passthrough.
- Attaches to the slave-side user AXI port of the AIB AXI bridge and completes forwarded AW/W/AR requests with B/R responses.
- Lets bridge simulations and FPGA bring-up run without a hand-driven response model.
- Single beat only: AxLEN, AxSIZE and AxBURST are ignored.

Parameters:
- DATA_WIDTH, 64, R/W data width in bits; must be 32 or 64.
- ADDR_WIDTH, 32, address width in bits.
- ID_WIDTH, 4, AXI ID width.
- DEPTH, 256, number of DATA_WIDTH words; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk_wr  in  1  single clock for all five channels.
- rst_wr_n  in  1  asynchronous active-low reset.
- awvalid/awready  in/out  1/1  AW handshake.
- awaddr  in  ADDR_WIDTH  write byte address.
- awid  in  ID_WIDTH  write ID.
- wvalid/wready  in/out  1/1  W handshake.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte enables.
- bvalid/bready  out/in  1/1  B handshake.
- bresp  out  2  write response.
- bid  out  ID_WIDTH  write response ID.
- arvalid/arready  in/out  1/1  AR handshake.
- araddr  in  ADDR_WIDTH  read byte address.
- arid  in  ID_WIDTH  read ID.
- rvalid/rready  out/in  1/1  R handshake.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response.
- rid  out  ID_WIDTH  read response ID.
- rlast  out  1  tied 1 whenever rvalid=1.

Behaviour:
- Reset values (async assert, sync deassert): awready=1, wready=1, arready=1, bvalid=0, rvalid=0; bresp, bid, rdata, rresp, rid = 0; rlast=0.
- Memory contents are not reset.
- Address decode:
  - off = addr - BASE_ADDR; word index = off >> log2(DATA_WIDTH/8); low byte-offset bits ignored.
  - In range iff addr >= BASE_ADDR and index < DEPTH.
- Write path: 1-entry AW holding register and 1-entry W holding register, filled independently.
  - awready=1 iff AW register empty; wready=1 iff W register empty.
  - AW and W may arrive in either order or in the same cycle.
- Write FSM states: W_IDLE, W_RESP.
  - W_IDLE→W_RESP on the first edge where both registers are full. On that edge:
    - If in range, the memory word is updated per wstrb byte lanes (wstrb=0 writes nothing, still OKAY).
    - bvalid<=1, bid<=held awid, bresp<=2'b00 in range or 2'b10 SLVERR out of range (no write).
    - Both registers are cleared.
  - If AW and W handshake on the same edge, bvalid rises on the following edge: 2-cycle handshake-to-bvalid latency.
  - W_RESP: hold bvalid/bid/bresp stable until bready. bvalid clears on the handshake edge.
  - New AW/W may be accepted into empty registers while in W_RESP, but do not commit until back in W_IDLE: at most one outstanding B.
- Read FSM states: R_IDLE, R_RESP.
  - arready=1 only in R_IDLE.
  - On the AR handshake edge:
    - rdata<=mem[index] (0 if out of range), rresp<=00 in range or 10 out of range, rid<=arid, rvalid<=1, rlast<=1.
    - Go to R_RESP. Latency: rvalid the cycle after the AR handshake.
  - R_RESP: hold all R outputs stable until rready. On the handshake edge rvalid<=0, rlast<=0, return to R_IDLE.
  - Next AR is accepted no earlier than the cycle after the R handshake.
- Same-edge write commit and AR handshake to the same word: R returns the old (pre-write) data; the write still lands.
- Read and write paths are otherwise fully independent and may complete in the same cycle.
- Reset mid-operation: pending AW/W and outstanding B/R are discarded; outputs go to reset values immediately.
- No assertion on AxLEN≠0. The design treats every request as single beat.

Test Plan:
- Write then read:
  - Stimulus: AW addr 0x1000, id 3, with W data 0x1234_5678_9ABC_DEF0, wstrb 0xFF in the same cycle; BASE_ADDR=0x1000.
  - Required: bvalid 2 cycles later, bid=3, bresp=00. Then AR 0x1000, id 5 → next cycle rvalid=1, rdata=0x1234_5678_9ABC_DEF0, rid=5, rresp=00, rlast=1.
- Decoupled AW/W:
  - Stimulus: W (0xAA..AA, 0xFF) to word 2, AW addr 0x1010 issued 4 cycles later.
  - Required: wready=0 after the W handshake until commit; bvalid 1 cycle after the AW handshake.
  - Then write 0x55..55 with wstrb=0x0F to 0x1010; reading 0x1010 returns 0xAAAA_AAAA_5555_5555.
- Out of range:
  - Stimulus: AW/W to 0x1000+8*256, then AR to 0x0FF8.
  - Required: bresp=10, memory unchanged; rresp=10, rdata=0.
- Backpressure:
  - Stimulus: hold bready=0 and rready=0 for 10 cycles.
  - Required: bvalid/bid/bresp and rvalid/rdata/rid stable; awready/wready deassert once refilled; arready=0; a second B appears only after the first B handshake.
- Same-edge hazard:
  - Stimulus: word 4 holds 0x11..11; commit of 0x22..22 to word 4 on the same edge as the AR handshake to word 4.
  - Required: R returns 0x11..11; a subsequent read returns 0x22..22.
- Async reset:
  - Stimulus: assert rst_wr_n mid-R_RESP with rvalid=1 and an AW held.
  - Required: rvalid=0 and awready=wready=arready=1 within the reset; no B issued afterwards.

Source files
------------

// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite memory-backed subordinate with ID passthrough, single-beat only.
// Independent write (AW/W holding registers + B FSM) and read (AR/R FSM) paths.
module axi_lite_mem_responder #(
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           ID_WIDTH   = 4,
  parameter int unsigned           DEPTH      = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk_wr,
  input  logic                    rst_wr_n,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  output logic [ID_WIDTH-1:0]     bid,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [ID_WIDTH-1:0]     arid,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic [ID_WIDTH-1:0]     rid,
  output logic                    rlast
);

  localparam int unsigned           STRB_W  = DATA_WIDTH / 8;
  localparam int unsigned           SHIFT   = $clog2(STRB_W);
  localparam int unsigned           IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_RESP} rstate_e;

  function automatic logic [ADDR_WIDTH-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
    return (a - BASE_ADDR) >> SHIFT;
  endfunction

  function automatic logic hit(input logic [ADDR_WIDTH-1:0] a);
    return (a >= BASE_ADDR) && (word_of(a) < DEPTH_A);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  wstate_e               w_state_q, w_state_d;
  logic                  aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0]     w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic                  mem_we;
  logic [IDX_W-1:0]      wr_idx, rd_idx;

  rstate_e               r_state_q, r_state_d;
  logic                  rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;

  assign wr_idx  = IDX_W'(word_of(aw_addr_q));
  assign rd_idx  = IDX_W'(word_of(araddr));
  assign awready = !aw_full_q;
  assign wready  = !w_full_q;
  assign arready = (r_state_q == R_IDLE);
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign bid     = bid_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rid     = rid_q;
  assign rlast   = rlast_q;

  // Holding registers fill whenever empty, even in W_RESP; commit only from W_IDLE.
  always_comb begin
    w_state_d = w_state_q;
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    aw_id_d   = aw_id_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    mem_we    = 1'b0;
    if (awvalid && !aw_full_q) begin
      aw_full_d = 1'b1;
      aw_addr_d = awaddr;
      aw_id_d   = awid;
    end
    if (wvalid && !w_full_q) begin
      w_full_d = 1'b1;
      w_data_d = wdata;
      w_strb_d = wstrb;
    end
    case (w_state_q)
      W_IDLE: begin
        if (aw_full_q && w_full_q) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bid_d     = aw_id_q;
          bresp_d   = hit(aw_addr_q) ? 2'b00 : 2'b10;
          mem_we    = hit(aw_addr_q);
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Memory read uses the pre-edge array, so a same-edge write commit returns old data.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid) begin
          r_state_d = R_RESP;
          rvalid_d  = 1'b1;
          rlast_d   = 1'b1;
          rid_d     = arid;
          rresp_d   = hit(araddr) ? 2'b00 : 2'b10;
          rdata_d   = hit(araddr) ? mem_q[rd_idx] : '0;
        end
      end
      R_RESP: begin
        if (rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      w_state_q <= W_IDLE;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      aw_id_q   <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      bid_q     <= '0;
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rid_q     <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      aw_id_q   <= aw_id_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      r_state_q <= r_state_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
    end
  end

  always_ff @(posedge clk_wr) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (w_strb_q[b]) mem_q[wr_idx][8*b +: 8] <= w_data_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Directed self-checking bench for axi_lite_mem_responder (64-bit data, BASE 0x1000).
module tb_axi_lite_mem_responder;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 32;
  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          awvalid = 1'b0, awready;
  logic [AW-1:0] awaddr = '0;
  logic [IW-1:0] awid = '0;
  logic          wvalid = 1'b0, wready;
  logic [DW-1:0] wdata = '0;
  logic [7:0]    wstrb = '0;
  logic          bvalid, bready = 1'b0;
  logic [1:0]    bresp;
  logic [IW-1:0] bid;
  logic          arvalid = 1'b0, arready;
  logic [AW-1:0] araddr = '0;
  logic [IW-1:0] arid = '0;
  logic          rvalid, rready = 1'b0;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic [IW-1:0] rid;
  logic          rlast;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axi_lite_mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .DEPTH(256), .BASE_ADDR(32'h1000)
  ) dut (
    .clk_wr(clk), .rst_wr_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast)
  );

  // Same-cycle AW+W, then B sampled after the commit edge and acknowledged.
  task automatic do_write(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [DW-1:0] d,
                          input logic [7:0] s, output logic bv, output logic [1:0] br, output logic [IW-1:0] bi);
    @(negedge clk);
    awvalid = 1'b1; awaddr = a; awid = id; wvalid = 1'b1; wdata = d; wstrb = s;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    bv = bvalid; br = bresp; bi = bid;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [IW-1:0] id, output logic rv,
                         output logic [DW-1:0] rd, output logic [1:0] rr, output logic [IW-1:0] ri, output logic rl);
    @(negedge clk);
    arvalid = 1'b1; araddr = a; arid = id;
    @(negedge clk);
    arvalid = 1'b0;
    rv = rvalid; rd = rdata; rr = rresp; ri = rid; rl = rlast;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({awready, wready, arready, bvalid, rvalid, rlast} !== 6'b111000) begin
      fails++; $display("FAIL reset_ctrl got %b want 111000", {awready, wready, arready, bvalid, rvalid, rlast});
    end
    tests++;
    if ({bresp, bid, rresp, rid, rdata} !== '0) begin
      fails++; $display("FAIL reset_data got bresp=%b bid=%0d rresp=%b rid=%0d rdata=%h want all 0", bresp, bid, rresp, rid, rdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    logic bv, rv, rl; logic [1:0] br, rr; logic [IW-1:0] bi, ri; logic [DW-1:0] rd;
    @(negedge clk);
    awvalid = 1'b1; awaddr = 32'h1000; awid = 4'd3; wvalid = 1'b1; wdata = 64'h1234_5678_9ABC_DEF0; wstrb = 8'hFF;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    tests++;
    if (bvalid !== 1'b0) begin fails++; $display("FAIL wr_early_bvalid got %b want 0", bvalid); end
    @(negedge clk);
    tests++;
    if ({bvalid, bid, bresp} !== {1'b1, 4'd3, 2'b00}) begin
      fails++; $display("FAIL wr_b got bvalid=%b bid=%0d bresp=%b want 1/3/00", bvalid, bid, bresp);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    tests++;
    if (bvalid !== 1'b0) begin fails++; $display("FAIL wr_b_clear got %b want 0", bvalid); end
    do_read(32'h1000, 4'd5, rv, rd, rr, ri, rl);
    tests++;
    if ({rv, rd, rr, ri, rl} !== {1'b1, 64'h1234_5678_9ABC_DEF0, 2'b00, 4'd5, 1'b1}) begin
      fails++; $display("FAIL rd_basic got rv=%b rdata=%h rresp=%b rid=%0d rlast=%b want 1/123456789abcdef0/00/5/1", rv, rd, rr, ri, rl);
    end
    tests++;
    if ({rvalid, rlast, arready} !== 3'b001) begin
      fails++; $display("FAIL rd_clear got rvalid,rlast,arready=%b want 001", {rvalid, rlast, arready});
    end
  endtask

  task automatic test_decoupled();
    logic bv, rv, rl; logic [1:0] br, rr; logic [IW-1:0] bi, ri; logic [DW-1:0] rd;
    int bad;
    @(negedge clk);
    wvalid = 1'b1; wdata = {16{4'hA}}; wstrb = 8'hFF;
    @(negedge clk);
    wvalid = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (wready !== 1'b0 || bvalid !== 1'b0) bad++;
      if (i < 3) @(negedge clk);
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL w_held got %0d bad cycles want 0 (wready/bvalid must stay 0)", bad); end
    awvalid = 1'b1; awaddr = 32'h1010; awid = 4'd7;
    @(negedge clk);
    awvalid = 1'b0;
    tests++;
    if (bvalid !== 1'b0) begin fails++; $display("FAIL dec_early_bvalid got %b want 0", bvalid); end
    @(negedge clk);
    tests++;
    if ({bvalid, bid, bresp, wready} !== {1'b1, 4'd7, 2'b00, 1'b1}) begin
      fails++; $display("FAIL dec_b got bvalid=%b bid=%0d bresp=%b wready=%b want 1/7/00/1", bvalid, bid, bresp, wready);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    do_write(32'h1010, 4'd1, {16{4'h5}}, 8'h0F, bv, br, bi);
    tests++;
    if ({bv, br} !== 3'b100) begin fails++; $display("FAIL strb_b got bvalid=%b bresp=%b want 1/00", bv, br); end
    do_read(32'h1010, 4'd2, rv, rd, rr, ri, rl);
    tests++;
    if (rd !== 64'hAAAA_AAAA_5555_5555) begin fails++; $display("FAIL strb_rd got %h want aaaaaaaa55555555", rd); end
  endtask

  task automatic test_out_of_range();
    logic bv, rv, rl; logic [1:0] br, rr; logic [IW-1:0] bi, ri; logic [DW-1:0] rd;
    do_write(32'h1800, 4'd9, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, bv, br, bi);
    tests++;
    if ({bv, br, bi} !== {1'b1, 2'b10, 4'd9}) begin
      fails++; $display("FAIL oor_b got bvalid=%b bresp=%b bid=%0d want 1/10/9", bv, br, bi);
    end
    do_read(32'h1000, 4'd1, rv, rd, rr, ri, rl);
    tests++;
    if (rd !== 64'h1234_5678_9ABC_DEF0) begin fails++; $display("FAIL oor_nowrite got %h want 123456789abcdef0", rd); end
    do_read(32'h0FF8, 4'd4, rv, rd, rr, ri, rl);
    tests++;
    if ({rv, rr, rd, ri} !== {1'b1, 2'b10, 64'h0, 4'd4}) begin
      fails++; $display("FAIL oor_rd got rv=%b rresp=%b rdata=%h rid=%0d want 1/10/0/4", rv, rr, rd, ri);
    end
    do_write(32'h17FC, 4'd2, 64'h0BAD_F00D_CAFE_0001, 8'hFF, bv, br, bi);
    do_read(32'h17F8, 4'd3, rv, rd, rr, ri, rl);
    tests++;
    if ({br, rr, rd} !== {2'b00, 2'b00, 64'h0BAD_F00D_CAFE_0001}) begin
      fails++; $display("FAIL last_word got bresp=%b rresp=%b rdata=%h want 00/00/0badf00dcafe0001", br, rr, rd);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    @(negedge clk);
    awvalid = 1'b1; awaddr = 32'h1030; awid = 4'd1; wvalid = 1'b1; wdata = 64'h0101_0101_0101_0101; wstrb = 8'hFF;
    arvalid = 1'b1; araddr = 32'h1000; arid = 4'd9;
    @(negedge clk);
    arvalid = 1'b0;
    awaddr = 32'h1038; awid = 4'd2; wdata = 64'h0202_0202_0202_0202;
    @(negedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tests++;
      if ({bvalid, bid, bresp, rvalid, rid, rresp, rlast, arready, awready, wready} !==
          {1'b1, 4'd1, 2'b00, 1'b1, 4'd9, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0} || rdata !== 64'h1234_5678_9ABC_DEF0) begin
        fails++; bad++;
        $display("FAIL bp_hold cyc %0d got bvalid=%b bid=%0d rvalid=%b rid=%0d rdata=%h arready=%b awready=%b wready=%b",
                 i, bvalid, bid, rvalid, rid, rdata, arready, awready, wready);
      end
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    tests++;
    if (bvalid !== 1'b0) begin fails++; $display("FAIL bp_gap got bvalid=%b want 0", bvalid); end
    @(negedge clk);
    tests++;
    if ({bvalid, bid} !== {1'b1, 4'd2}) begin fails++; $display("FAIL bp_second_b got bvalid=%b bid=%0d want 1/2", bvalid, bid); end
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    tests++;
    if ({bvalid, rvalid, arready} !== 3'b001) begin
      fails++; $display("FAIL bp_drain got bvalid,rvalid,arready=%b want 001", {bvalid, rvalid, arready});
    end
  endtask

  task automatic test_same_edge();
    logic bv, rv, rl; logic [1:0] br, rr; logic [IW-1:0] bi, ri; logic [DW-1:0] rd;
    do_write(32'h1020, 4'd0, {16{4'h1}}, 8'hFF, bv, br, bi);
    @(negedge clk);
    awvalid = 1'b1; awaddr = 32'h1020; awid = 4'd4; wvalid = 1'b1; wdata = {16{4'h2}}; wstrb = 8'hFF;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    arvalid = 1'b1; araddr = 32'h1020; arid = 4'd6;
    @(negedge clk);
    arvalid = 1'b0;
    tests++;
    if ({rvalid, bvalid, rdata} !== {1'b1, 1'b1, {16{4'h1}}}) begin
      fails++; $display("FAIL hazard_old got rvalid=%b bvalid=%b rdata=%h want 1/1/1111111111111111", rvalid, bvalid, rdata);
    end
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    do_read(32'h1020, 4'd6, rv, rd, rr, ri, rl);
    tests++;
    if (rd !== {16{4'h2}}) begin fails++; $display("FAIL hazard_new got %h want 2222222222222222", rd); end
  endtask

  task automatic test_async_reset();
    int bad;
    @(negedge clk);
    arvalid = 1'b1; araddr = 32'h1010; arid = 4'd8;
    @(negedge clk);
    arvalid = 1'b0;
    awvalid = 1'b1; awaddr = 32'h1000; awid = 4'hA;
    @(negedge clk);
    awvalid = 1'b0;
    tests++;
    if ({rvalid, awready} !== 2'b10) begin fails++; $display("FAIL ar_pre got rvalid,awready=%b want 10", {rvalid, awready}); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({rvalid, rlast, bvalid, awready, wready, arready, rid} !== {6'b000111, 4'd0}) begin
      fails++; $display("FAIL async_rst got rvalid=%b rlast=%b bvalid=%b awready=%b wready=%b arready=%b rid=%0d want 0/0/0/1/1/1/0",
                        rvalid, rlast, bvalid, awready, wready, arready, rid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wvalid = 1'b1; wdata = 64'hFFFF_0000_FFFF_0000; wstrb = 8'hFF;
    @(negedge clk);
    wvalid = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bvalid !== 1'b0) bad++;
      @(negedge clk);
    end
    tests++;
    if (bad != 0 || wready !== 1'b0) begin
      fails++; $display("FAIL rst_no_b got %0d bvalid cycles wready=%b want 0 cycles wready=0", bad, wready);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_decoupled();
    test_out_of_range();
    test_backpressure();
    test_same_edge();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
